// File: rtl/reposicao_sequenciador_if.sv
// Handshake/bus bundle for reposicao_sequenciador: request side (start/qty/abort)
// and status side (busy/count/remaining/done). abort exists only with REPOSICAO_ABORT_EN.
interface reposicao_sequenciador_if #(
  parameter int QTY_W = 4
) ();
  logic             start;
  logic [QTY_W-1:0] qty;
`ifdef REPOSICAO_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             count;
  logic [QTY_W-1:0] remaining;
  logic             done;

`ifdef REPOSICAO_ABORT_EN
  modport master (output start, qty, abort, input busy, count, remaining, done);
  modport slave  (input start, qty, abort, output busy, count, remaining, done);
`else
  modport master (output start, qty, input busy, count, remaining, done);
  modport slave  (input start, qty, output busy, count, remaining, done);
`endif
endinterface

// File: rtl/reposicao_sequenciador.sv
// Replenishment pulse sequencer: one PULSE_LEN-wide count pulse per unit, one unit every
// PERIOD cycles, start/busy/done handshake. Optional abort input under REPOSICAO_ABORT_EN.
module reposicao_sequenciador #(
  parameter int PERIOD    = 4,
  parameter int PULSE_LEN = 2,
  parameter int QTY_W     = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  reposicao_sequenciador_if.slave bus
);

  localparam int PH_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST      = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_PULSE_END = PH_W'(PULSE_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [QTY_W-1:0] remaining_q, remaining_d;
  logic             abort_req;

`ifdef REPOSICAO_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        // A zero-quantity request is dropped so no empty run or done strobe appears.
        if (bus.start && (bus.qty != '0)) begin
          remaining_d = bus.qty;
          phase_d     = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_req) begin
          // Abort wins over a coinciding wrap or final-unit completion.
          state_d     = S_IDLE;
          phase_d     = '0;
          remaining_d = '0;
        end else if (phase_q == PH_LAST) begin
          phase_d     = '0;
          remaining_d = remaining_q - QTY_W'(1);
          if (remaining_q == QTY_W'(1)) begin
            state_d = S_DONE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        phase_d     = '0;
        remaining_d = '0;
      end
      default: begin
        state_d     = S_IDLE;
        phase_d     = '0;
        remaining_d = '0;
      end
    endcase
  end

  // remaining_q is already zero outside RUN, so it drives the port directly.
  assign bus.busy      = (state_q == S_RUN);
  assign bus.count     = (state_q == S_RUN) && (phase_q != '0) && (phase_q <= PH_PULSE_END);
  assign bus.remaining = remaining_q;
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reposicao_sequenciador.sv
// Drives two sequencers (4/2 and 5/1 timing) from one stimulus stream and compares every
// output each cycle against a per-run arithmetic model of the documented timeline.
module tb_reposicao_sequenciador;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  reposicao_sequenciador_if #(.QTY_W(4)) bus_a ();
  reposicao_sequenciador_if #(.QTY_W(4)) bus_b ();

  reposicao_sequenciador #(.PERIOD(4), .PULSE_LEN(2), .QTY_W(4)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  reposicao_sequenciador #(.PERIOD(5), .PULSE_LEN(1), .QTY_W(4)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model of each run: accepted quantity and the cycle in which busy first rises.
  bit act [2];
  int t0  [2];
  int qq  [2];

  int high_cnt [2];
  int busy_cnt [2];
  int done_cnt [2];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int per_of(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic int len_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // 0 = idle, 1 = running, 2 = done cycle, judged for the current value of cyc.
  function automatic int mode_of(input int i);
    int off;
    if (!act[i]) return 0;
    off = cyc - t0[i];
    if (off < qq[i] * per_of(i)) return 1;
    if (off == qq[i] * per_of(i)) return 2;
    return 0;
  endfunction

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      high_cnt[i] = 0;
      busy_cnt[i] = 0;
      done_cnt[i] = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input int q, input bit ab);
    int md, off, p, l;
    int e_busy, e_cnt, e_rem, e_done;
    int o_busy, o_cnt, o_rem, o_done;
    string nm;
    RST         = r;
    bus_a.start = s;
    bus_b.start = s;
    bus_a.qty   = 4'(q);
    bus_b.qty   = 4'(q);
`ifdef REPOSICAO_ABORT_EN
    bus_a.abort = ab;
    bus_b.abort = ab;
`endif
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      md = mode_of(i);
      if (r) begin
        act[i] = 1'b0;
      end else if (md == 0 && s && (q % 16) != 0) begin
        act[i] = 1'b1;
        t0[i]  = cyc + 1;
        qq[i]  = q % 16;
      end
`ifdef REPOSICAO_ABORT_EN
      if (!r && ab && md == 1) act[i] = 1'b0;
`endif
    end
    cyc++;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      p  = per_of(i);
      l  = len_of(i);
      md = mode_of(i);
      off = cyc - t0[i];
      e_busy = (md == 1) ? 1 : 0;
      e_cnt  = (md == 1 && (off % p) >= 1 && (off % p) <= l) ? 1 : 0;
      e_rem  = (md == 1) ? (qq[i] - off / p) : 0;
      e_done = (md == 2) ? 1 : 0;
      if (i == 0) begin
        o_busy = int'(bus_a.busy);  o_cnt  = int'(bus_a.count);
        o_rem  = int'(bus_a.remaining); o_done = int'(bus_a.done);
        nm = "a";
      end else begin
        o_busy = int'(bus_b.busy);  o_cnt  = int'(bus_b.count);
        o_rem  = int'(bus_b.remaining); o_done = int'(bus_b.done);
        nm = "b";
      end
      check({nm, ".busy"}, o_busy, e_busy);
      check({nm, ".count"}, o_cnt, e_cnt);
      check({nm, ".remaining"}, o_rem, e_rem);
      check({nm, ".done"}, o_done, e_done);
      high_cnt[i] += o_cnt;
      busy_cnt[i] += o_busy;
      done_cnt[i] += o_done;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    RST         = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_a.qty   = '0;
    bus_b.qty   = '0;
`ifdef REPOSICAO_ABORT_EN
    bus_a.abort = 1'b0;
    bus_b.abort = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t0[i] = 0; qq[i] = 0;
    end
    clr();
    @(negedge CLK);

    // Reset for two cycles, then a qty=3 run.
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    clr();
    step(1'b0, 1'b1, 3, 1'b0);
    idle(18);
    check("a.run3_high", high_cnt[0], 6);
    check("a.run3_busy", busy_cnt[0], 12);
    check("a.run3_done", done_cnt[0], 1);
    check("b.run3_high", high_cnt[1], 3);
    check("b.run3_busy", busy_cnt[1], 15);
    check("b.run3_done", done_cnt[1], 1);

    // start held with qty=0 for 10 cycles.
    clr();
    repeat (10) step(1'b0, 1'b1, 0, 1'b0);
    check("a.qty0_busy", busy_cnt[0] + high_cnt[0] + done_cnt[0], 0);
    check("b.qty0_busy", busy_cnt[1] + high_cnt[1] + done_cnt[1], 0);

    // qty=2 run with qty=5 requests through RUN and the DONE cycle of dut_a.
    clr();
    step(1'b0, 1'b1, 2, 1'b0);
    repeat (9) step(1'b0, 1'b1, 5, 1'b0);
    idle(6);
    check("a.ignore_high", high_cnt[0], 4);
    check("a.ignore_done", done_cnt[0], 1);
    check("b.ignore_high", high_cnt[1], 2);
    check("b.ignore_done", done_cnt[1], 1);

    // Reset during dut_a's third count-high cycle of a qty=4 run.
    clr();
    step(1'b0, 1'b1, 4, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 0, 1'b0);
    check("a.rst_done", done_cnt[0], 0);
    step(1'b0, 1'b1, 1, 1'b0);
    idle(8);
    check("a.after_rst_done", done_cnt[0], 1);
    check("b.after_rst_done", done_cnt[1], 1);

    // Largest quantity.
    clr();
    step(1'b0, 1'b1, 15, 1'b0);
    idle(80);
    check("a.q15_busy", busy_cnt[0], 60);
    check("a.q15_high", high_cnt[0], 30);
    check("b.q15_busy", busy_cnt[1], 75);
    check("b.q15_high", high_cnt[1], 15);
    check("b.q15_done", done_cnt[1], 1);

`ifdef REPOSICAO_ABORT_EN
    // Abort on dut_a's final-wrap cycle of a qty=2 run.
    clr();
    step(1'b0, 1'b1, 2, 1'b0);
    idle(7);
    step(1'b0, 1'b0, 0, 1'b1);
    idle(12);
    check("a.abort_done", done_cnt[0], 0);
    check("b.abort_done", done_cnt[1], 0);
`endif

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      step(($urandom % 40) == 0, ($urandom % 4) == 0, int'($urandom % 16), ($urandom % 30) == 0);
    end
    idle(90);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reposicao_sequenciador.md
# reposicao_sequenciador

Parametrised replenishment pulse sequencer for the stock-control datapath. It accepts a requested quantity and emits one fixed-width `count` pulse per unit, at a programmable period. Each pulse drives one replenishment step downstream. It generalises the free-running two-of-four pulse generator with the following additions:
- working reset;
- start/busy/done handshake;
- unit down-counter;
- parametrised period and pulse width;
- optional abort.

## Interface
Parameters:
- `PERIOD`, default 4: cycles per unit. Must be ≥ 2.
- `PULSE_LEN`, default 2: high cycles of `count` per unit. Must satisfy 1 ≤ `PULSE_LEN` ≤ `PERIOD`-1.
- `QTY_W`, default 4: width of quantity and remaining count.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `qty`  in  `QTY_W`  units to deliver; sampled with `start`.
- `abort`  in  1  cancel the current run. Present only with `REPOSICAO_ABORT_EN`.
- `busy`  out  1  high in RUN.
- `count`  out  1  replenishment pulse.
- `remaining`  out  `QTY_W`  units not yet completed.
- `done`  out  1  one-cycle completion strobe.

## Operation
- Internal phase counter: width `$clog2(PERIOD)`, range 0..`PERIOD`-1.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs are all 0.
  - `start`=1 with `qty`≠0 loads `remaining`←`qty` and phase←0, then moves to RUN.
  - `start` with `qty`=0 is ignored: no state change and no `done`.
- RUN:
  - `busy`=1.
  - Phase increments each cycle.
  - `count` = 1 exactly when phase ∈ [1, `PULSE_LEN`]. This is a combinational decode of the registered state and phase.
  - On a cycle with phase = `PERIOD`-1, the next phase is 0 and `remaining` decrements by 1.
  - If `remaining` was 1 at that wrap, the next state is DONE.
- DONE:
  - `done`=1, `busy`=0, `count`=0, `remaining`=0, for exactly one cycle.
  - Next state is always IDLE.
  - `start` is ignored in DONE.
- `start` asserted in RUN or DONE is ignored. It is not queued.
- No arithmetic wrap: `remaining` never decrements below 0. `qty` = 2^`QTY_W`-1 is legal.
- `RST`=1 at any edge, in any state:
  - next state IDLE, phase 0, `remaining` 0, all outputs 0;
  - a run in progress is abandoned without `done`;
  - reset has priority over `start` and `abort`.

## Timing
- Reset values: `busy`=0, `count`=0, `remaining`=0, `done`=0.
- Definitions: `start` accepted in cycle T with `qty`=Q; P = `PERIOD`, L = `PULSE_LEN`.
- Cycle T+1: `busy`=1, phase=0, `remaining`=Q.
- Unit k (k = 0..Q-1):
  - `count` high in cycles T+1+kP+1 through T+1+kP+L;
  - `remaining` reads Q-k during unit k.
- `done`=1 in cycle T+1+QP; `busy` is 0 in that cycle.
- IDLE from T+2+QP onward. Earliest next accepted `start` is in cycle T+2+QP.
- Start-to-first-pulse latency: 2 cycles.
- Total `count`-high cycles per run: Q·L.
- With defaults, each unit yields the pattern 0,1,1,0 on `count`.

## Configuration
- Macro: `REPOSICAO_ABORT_EN`.
- Defined:
  - the `abort` port exists;
  - `abort`=1 in RUN sends the next state to IDLE, with phase 0, `remaining` 0, `count` 0 and `busy` 0 from the next cycle;
  - no `done` strobe is produced;
  - abort takes priority over a simultaneous phase wrap or final-unit completion;
  - `abort` in IDLE or DONE is ignored.
- Undefined:
  - the `abort` port is absent;
  - a run ends only on completion or `RST`.

## Test plan
- Defaults, `RST` 2 cycles, then `start`=1 with `qty`=3 -> `busy` high for 12 cycles; `count` pattern 0,1,1,0 repeated 3×; `remaining` 3,2,1; `done` single cycle at T+13; 6 total `count`-high cycles.
- `start`=1 with `qty`=0 -> stays IDLE; `busy`, `count` and `done` all 0 for 10 cycles.
- Second `start` with `qty`=5 issued while busy on a `qty`=2 run -> ignored; exactly 2 units delivered; a `start` in the DONE cycle is also ignored.
- `RST` asserted at the third `count`-high cycle of a `qty`=4 run -> next cycle all outputs 0, no `done`; a subsequent `start` with `qty`=1 behaves normally.
- `PERIOD`=5, `PULSE_LEN`=1, `qty`=15 -> 75 busy cycles; one `count`-high cycle per unit at phase 1; `remaining` reaches 0 without wrap; `done` once.
- With `REPOSICAO_ABORT_EN`: `abort` on the final-wrap cycle of a `qty`=2 run -> IDLE next cycle, `done` never asserted, `remaining`=0.
